// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with a registered read port.
// Owns the pointers, the occupancy and the flow control, plus a 2-entry output buffer for 1 word/cycle output.
module dpram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_wr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_wr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         FULL_CNT  = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic       wr;
  logic       pop;
  logic       rd_issue;
  logic [2:0] occ;

  assign in_ready   = reset && (ram_cnt_q != FULL_CNT);
  assign wr         = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  // Buffer slots still committed after this edge; a read is only issued if one stays free.
  assign occ        = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign rd_issue   = (ram_cnt_q != '0) && (occ < 3'd2);

  assign ram_addr_a = wr_ptr_q;
  assign ram_data_a = in_data;
  assign ram_wr_a   = wr;
  assign ram_addr_b = rd_ptr_q;
  assign ram_data_b = '0;
  assign ram_wr_b   = 1'b0;

  assign out_data   = buf0_q;
  assign out_valid  = (buf_cnt_q != 2'd0);
  assign count      = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rd_issue;
    ram_cnt_d  = ram_cnt_q + CW'(wr) - CW'(rd_issue);
    count_d    = count_q + CW'(wr) - CW'(pop);
    buf_cnt_d  = buf_cnt_q + 2'(inflight_q) - 2'(pop);

    if (wr) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end

    // Pop shifts the queue; the returning read word lands behind whatever remains.
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if ((buf_cnt_q - 2'(pop)) == 2'd0) begin
        buf0_d = ram_q_b;
      end else begin
        buf1_d = ram_q_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] count;
  logic [5:0] ram_addr_a;
  logic [7:0] ram_data_a;
  logic       ram_wr_a;
  logic [5:0] ram_addr_b;
  logic [7:0] ram_data_b;
  logic       ram_wr_b;
  logic [7:0] ram_q_b;

  logic [7:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(36)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_wr_a(ram_wr_a),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_wr_b(ram_wr_b),
    .ram_q_b(ram_q_b)
  );

  always @(posedge clk) begin
    if (ram_wr_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp;
    bit started;
    bit held;
    logic [7:0] held_val;
    int wrote;

    // 1: reset state
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ram_wr_a", ram_wr_a, 0);
    chk("rst_ram_wr_b", ram_wr_b, 0);
    chk("rst_ram_data_b", ram_data_b, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_count", count, 0);

    // 2: single word latency
    in_data = 8'hAB; in_valid = 1'b1;
    #1;
    chk("w1_ram_wr_a", ram_wr_a, 1);
    chk("w1_ram_addr_a", ram_addr_a, 0);
    chk("w1_ram_data_a", ram_data_a, 8'hAB);
    @(negedge clk);
    in_valid = 1'b0;
    chk("w1_count_e", count, 1);
    chk("w1_valid_e", out_valid, 0);
    @(negedge clk);
    chk("w1_valid_e1", out_valid, 0);
    @(negedge clk);
    chk("w1_valid_e2", out_valid, 1);
    chk("w1_data_e2", out_data, 8'hAB);
    chk("w1_count_e2", count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("w1_pop_valid", out_valid, 0);
    chk("w1_pop_count", count, 0);
    out_ready = 1'b0;

    // 3: fill to capacity, then drain in order
    for (int i = 0; i < 38; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      #1;
      chk("fill_in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_data = 8'd38;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_ram_wr_a", ram_wr_a, 0);
    chk("full_count", count, 38);
    @(negedge clk);
    chk("full_count_hold", count, 38);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 38; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_count", count, 0);
    chk("drain_in_ready", in_ready, 1);

    // 4: continuous streaming across the pointer wrap
    exp = 1; started = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      if (c < 100) begin
        in_data = 8'(c + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("wrap_data", out_data, 32'(exp));
        exp++;
        started = 1'b1;
      end else if (started && exp <= 100) begin
        chk("wrap_gap", out_valid, 1);
      end
      @(negedge clk);
    end
    chk("wrap_total", exp, 101);
    chk("wrap_count", count, 0);

    // 5: output backpressure 1010...
    exp = 200; wrote = 0; held = 1'b0; held_val = 8'h00;
    for (int c = 0; c < 60; c++) begin
      out_ready = (c % 2 == 0);
      if (wrote < 20) begin
        in_data = 8'(200 + wrote); in_valid = 1'b1;
        chk("bp_in_ready", in_ready, 1);
        wrote++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("bp_data", out_data, 32'(exp));
        if (held) chk("bp_stable", out_data, held_val);
        if (out_ready) begin
          exp++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = 8'(exp);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("bp_total", exp, 220);
    chk("bp_empty", out_valid, 0);
    chk("bp_count", count, 0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(50 + i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_count", count, 20);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, 50);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    in_data = 8'h5A; in_valid = 1'b1;
    #1;
    chk("post_addr_a", ram_addr_a, 0);
    chk("post_wr_a", ram_wr_a, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 8'h5A);
    chk("post_count", count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_pop_valid", out_valid, 0);
    chk("post_pop_count", count, 0);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
